// File: rtl/ila_pkg.sv
// Shared definitions for the ILA sample-FIFO readout path.
package ila_pkg;

    // Readout FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_LEN_H = 3'd2,
        ST_LEN_L = 3'd3,
        ST_POP   = 3'd4,
        ST_CAP   = 3'd5,
        ST_SHIFT = 3'd6,
        ST_FIN   = 3'd7
    } state_e;

    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

    // Bytes needed to carry a word of w bits (ceil(w/8))
    function automatic int unsigned nbytes(input int unsigned w);
        return (w + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/ila_byte_serializer.sv
// Holds one byte-padded word and presents it LSB byte first; flags the final byte.
module ila_byte_serializer
    import ila_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 20,
    localparam int unsigned NBYTES    = nbytes(DATA_WIDTH),
    localparam int unsigned SW        = NBYTES * 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [SW-1:0] load_word_i,
    input  logic          shift_i,
    output logic [7:0]    byte_o,
    output logic          last_o
);

    localparam int unsigned IDX_W = $clog2(NBYTES + 1);

    logic [SW-1:0]    shift_q;
    logic [IDX_W-1:0] idx_q;

    // Load a new word or drop the byte just accepted by the link
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (load_i) begin
            shift_q <= load_word_i;
            idx_q   <= '0;
        end else if (shift_i) begin
            shift_q <= shift_q >> 8;
            idx_q   <= idx_q + IDX_W'(1);
        end
    end

    assign byte_o = shift_q[7:0];
    assign last_o = (idx_q == IDX_W'(NBYTES - 1));

endmodule

// File: rtl/ila_fifo_reader.sv
// Pops NUM_WORDS samples from the ILA FIFO and frames them as a byte stream for the host link.
module ila_fifo_reader
    import ila_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 20,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [CNT_WIDTH-1:0]  num_words_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  words_sent_o,
    output logic                  fifo_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_do_i,
    input  logic                  fifo_empty_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i
);

    localparam int unsigned NBYTES = nbytes(DATA_WIDTH);
    localparam int unsigned SW     = NBYTES * 8;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] rem_q, rem_d;
    logic [CNT_WIDTH-1:0] words_q, words_d;
    logic                 busy_q, done_q, tx_valid_q;

    logic                 ser_load, ser_shift, ser_last;
    logic [SW-1:0]        ser_word;
    logic [7:0]           ser_byte;
    logic [15:0]          len16;
    logic                 xfer;
    logic                 pop_c;

    assign len16 = 16'(num_q);
    assign xfer  = tx_valid_q & tx_ready_i;
    assign pop_c = (state_q == ST_POP) & ~fifo_empty_i & ~abort_i & ~rst_i;

    // The serializer register doubles as the TX data register for header bytes too
    ila_byte_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (ser_load),
        .load_word_i (ser_word),
        .shift_i     (ser_shift),
        .byte_o      (ser_byte),
        .last_o      (ser_last)
    );

    // State, counters and registered status outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            rem_q      <= '0;
            words_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            rem_q      <= rem_d;
            words_q    <= words_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_FIN);
            tx_valid_q <= (state_d == ST_HDR) || (state_d == ST_LEN_H) ||
                          (state_d == ST_LEN_L) || (state_d == ST_SHIFT);
        end
    end

    // Next-state, counter updates and serializer control
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        rem_d     = rem_q;
        words_d   = words_q;
        ser_load  = 1'b0;
        ser_word  = '0;
        ser_shift = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    num_d    = num_words_i;
                    rem_d    = num_words_i;
                    words_d  = '0;
                    ser_load = 1'b1;
                    ser_word = SW'(HEADER_BYTE);
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    if (abort_i) begin
                        state_d = ST_FIN;
                    end else begin
                        ser_load = 1'b1;
                        ser_word = SW'(len16[15:8]);
                        state_d  = ST_LEN_H;
                    end
                end
            end
            ST_LEN_H: begin
                if (xfer) begin
                    if (abort_i) begin
                        state_d = ST_FIN;
                    end else begin
                        ser_load = 1'b1;
                        ser_word = SW'(len16[7:0]);
                        state_d  = ST_LEN_L;
                    end
                end
            end
            ST_LEN_L: begin
                if (xfer) begin
                    state_d = (abort_i || rem_q == '0) ? ST_FIN : ST_POP;
                end
            end
            ST_POP: begin
                if (abort_i) begin
                    state_d = ST_FIN;
                end else if (!fifo_empty_i) begin
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                if (abort_i) begin
                    state_d = ST_FIN;
                end else begin
                    ser_load = 1'b1;
                    ser_word = SW'(fifo_do_i);
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (xfer) begin
                    ser_shift = 1'b1;
                    if (ser_last) begin
                        words_d = words_q + CNT_WIDTH'(1);
                        rem_d   = rem_q - CNT_WIDTH'(1);
                        state_d = (abort_i || rem_q == CNT_WIDTH'(1)) ? ST_FIN : ST_POP;
                    end else if (abort_i) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign words_sent_o = words_q;
    assign fifo_en_o    = pop_c;
    assign tx_data_o    = ser_byte;
    assign tx_valid_o   = tx_valid_q;

endmodule
